// File: rtl/adxl357_read_scheduler.sv
// adxl357_read_scheduler: DRDY-driven ADXL357 burst reader sharing the I2C byte engine with host config writes
module adxl357_read_scheduler #(
    parameter int TIMEOUT_CYC = 100000,
    parameter int BURST_LEN = 11
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_drdy,
    input  logic        i_cfg_req,
    input  logic [7:0]  i_cfg_reg,
    input  logic [7:0]  i_cfg_data,
    output logic        o_cfg_ack,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready,
    output logic        o_cmd_rw,
    output logic [7:0]  o_cmd_reg,
    output logic [7:0]  o_cmd_wdata,
    output logic [3:0]  o_cmd_len,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    input  logic        i_done,
    input  logic        i_nack,
    output logic [31:0] o_accx,
    output logic [31:0] o_accy,
    output logic [31:0] o_accz,
    output logic [31:0] o_temp,
    output logic        o_sample_valid,
    output logic [31:0] o_status
);
    localparam int CW = $clog2(BURST_LEN + 2);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] BL = CW'(BURST_LEN);
    localparam logic [TW-1:0] TO = TW'(TIMEOUT_CYC);
    typedef enum logic [2:0] {IDLE, RD_CMD, RD_RECV, CFG_CMD, CFG_WAIT, UPDATE} state_t;
    state_t state, nxt;
    logic s1, s2, s3, pending, tout;
    logic [7:0] ovr, nck, cfg_reg_q, cfg_data_q;
    logic [TW-1:0] tmo;
    logic [CW-1:0] cnt;
    logic [7:0] rx_buf [BURST_LEN];
    logic rise_en, rd_go, take, waiting, tmo_hit, rd_ok, nack_inc;
    assign rise_en = s2 & ~s3 & i_enable;
    assign rd_go = i_enable & (pending | rise_en);
    assign take = (state == IDLE) & rd_go;
    assign waiting = (state == RD_RECV) | (state == CFG_WAIT);
    assign tmo_hit = waiting & ~i_done & (tmo == TO - 1'b1);
    // byte counter saturates one past BURST_LEN so over-long bursts are rejected
    assign rd_ok = ~i_nack & (cnt == BL);
    assign nack_inc = i_done & (((state == RD_RECV) & ~rd_ok) | ((state == CFG_WAIT) & i_nack));
    assign o_sample_valid = state == UPDATE;
    assign o_status = {8'h00, nck, ovr, 5'b0, pending, tout, state != IDLE};
    always_comb begin
        nxt = state;
        o_cmd_valid = 1'b0;
        o_cmd_rw = 1'b0;
        o_cmd_reg = 8'h00;
        o_cmd_wdata = 8'h00;
        o_cmd_len = 4'd0;
        o_cfg_ack = 1'b0;
        case (state)
            IDLE: nxt = rd_go ? RD_CMD : (i_cfg_req ? CFG_CMD : IDLE);
            RD_CMD: begin
                o_cmd_valid = 1'b1;
                o_cmd_rw = 1'b1;
                o_cmd_reg = 8'h06;
                o_cmd_len = 4'(BURST_LEN);
                nxt = i_cmd_ready ? RD_RECV : RD_CMD;
            end
            RD_RECV: nxt = i_done ? (rd_ok ? UPDATE : IDLE) : (tmo_hit ? IDLE : RD_RECV);
            CFG_CMD: begin
                o_cmd_valid = 1'b1;
                o_cmd_reg = cfg_reg_q;
                o_cmd_wdata = cfg_data_q;
                o_cmd_len = 4'd1;
                nxt = i_cmd_ready ? CFG_WAIT : CFG_CMD;
            end
            CFG_WAIT: begin
                o_cfg_ack = i_done | tmo_hit;
                nxt = (i_done | tmo_hit) ? IDLE : CFG_WAIT;
            end
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            {s3, s2, s1} <= 3'b000;
            pending <= 1'b0;
            tout <= 1'b0;
            ovr <= 8'h00;
            nck <= 8'h00;
            cfg_reg_q <= 8'h00;
            cfg_data_q <= 8'h00;
            tmo <= '0;
            cnt <= '0;
            o_temp <= 32'h0;
            o_accx <= 32'h0;
            o_accy <= 32'h0;
            o_accz <= 32'h0;
            for (int i = 0; i < BURST_LEN; i++) rx_buf[i] <= 8'h00;
        end else begin
            state <= nxt;
            {s3, s2, s1} <= {s2, s1, i_drdy};
            // an edge arriving as the flag is consumed re-arms it rather than counting as overrun
            pending <= take ? (pending & rise_en) : (pending | rise_en);
            if (rise_en & pending & ~take & (ovr != 8'hFF)) ovr <= ovr + 1'b1;
            if (nack_inc & (nck != 8'hFF)) nck <= nck + 1'b1;
            if (tmo_hit) tout <= 1'b1;
            tmo <= waiting ? tmo + 1'b1 : '0;
            cnt <= (state != RD_RECV) ? '0 : ((i_rx_valid & (cnt != BL + 1'b1)) ? cnt + 1'b1 : cnt);
            for (int i = 0; i < BURST_LEN; i++)
                if ((state == RD_RECV) & i_rx_valid & (cnt == CW'(i))) rx_buf[i] <= i_rx_data;
            if ((state == IDLE) & (nxt == CFG_CMD)) begin
                cfg_reg_q <= i_cfg_reg;
                cfg_data_q <= i_cfg_data;
            end
            if ((state == RD_RECV) & i_done & rd_ok) begin
                o_temp <= {20'h0, rx_buf[0][3:0], rx_buf[1]};
                o_accx <= {{12{rx_buf[2][7]}}, rx_buf[2], rx_buf[3], rx_buf[4][7:4]};
                o_accy <= {{12{rx_buf[5][7]}}, rx_buf[5], rx_buf[6], rx_buf[7][7:4]};
                o_accz <= {{12{rx_buf[8][7]}}, rx_buf[8], rx_buf[9], rx_buf[10][7:4]};
            end
        end
    end
endmodule

// File: tb/tb_adxl357_read_scheduler.sv
// tb_adxl357_read_scheduler: scoreboard bench driving a behavioural I2C byte engine against the scheduler
module tb_adxl357_read_scheduler;
    localparam int TO_CYC = 64;
    logic clk = 0, rst = 1, en = 0, drdy = 0, cfg_req = 0, cmd_ready = 0;
    logic rx_valid = 0, done = 0, nack = 0;
    logic [7:0] cfg_reg = 0, cfg_data = 0, rx_data = 0;
    logic cfg_ack, cmd_valid, cmd_rw, sample_valid;
    logic [7:0] cmd_reg, cmd_wdata;
    logic [3:0] cmd_len;
    logic [31:0] accx, accy, accz, temp, status;
    int n_cmp = 0, n_err = 0, n_samp = 0, n_ack = 0, n_acc = 0;
    logic [127:0] exp_q[$];
    logic [127:0] last_exp = '0;
    adxl357_read_scheduler #(.TIMEOUT_CYC(TO_CYC), .BURST_LEN(11)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_drdy(drdy),
        .i_cfg_req(cfg_req), .i_cfg_reg(cfg_reg), .i_cfg_data(cfg_data), .o_cfg_ack(cfg_ack),
        .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd_rw(cmd_rw), .o_cmd_reg(cmd_reg),
        .o_cmd_wdata(cmd_wdata), .o_cmd_len(cmd_len), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .i_done(done), .i_nack(nack), .o_accx(accx), .o_accy(accy), .o_accz(accz), .o_temp(temp),
        .o_sample_valid(sample_valid), .o_status(status)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [127:0] model(input logic [7:0] b [11]);
        logic [31:0] t, x, y, z;
        t = {20'h0, b[0][3:0], b[1]};
        x = {{12{b[2][7]}}, b[2], b[3], b[4][7:4]};
        y = {{12{b[5][7]}}, b[5], b[6], b[7][7:4]};
        z = {{12{b[8][7]}}, b[8], b[9], b[10][7:4]};
        return {t, x, y, z};
    endfunction
    always @(negedge clk) begin : mon
        logic [127:0] e;
        if (sample_valid) begin
            n_samp++;
            if (exp_q.size() == 0) check("unexpected_sample", 32'(sample_valid), 32'd0);
            else begin
                e = exp_q.pop_front();
                check("temp", temp, e[127:96]);
                check("accx", accx, e[95:64]);
                check("accy", accy, e[63:32]);
                check("accz", accz, e[31:0]);
            end
        end
        if (cfg_ack) n_ack++;
        if (cmd_valid && cmd_ready) n_acc++;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_drdy();
        drdy = 1;
        repeat (4) tick();
        drdy = 0;
        repeat (4) tick();
    endtask
    task automatic accept_cmd(input int hold, output logic [20:0] f);
        int t = 0;
        while (!cmd_valid && t < 200) begin
            tick();
            t++;
        end
        if (!cmd_valid) check("cmd_seen", 32'(cmd_valid), 32'd1);
        f = {cmd_rw, cmd_reg, cmd_wdata, cmd_len};
        repeat (hold) begin
            tick();
            check("cmd_stable", 32'({cmd_valid, cmd_rw, cmd_reg, cmd_wdata, cmd_len}), 32'({1'b1, f}));
        end
        cmd_ready = 1;
        tick();
        cmd_ready = 0;
    endtask
    task automatic send(input logic [7:0] b [11], input int n, input logic nk);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1;
            rx_data = b[i];
            tick();
        end
        rx_valid = 0;
        done = 1;
        nack = nk;
        tick();
        done = 0;
        nack = 0;
    endtask
    task automatic rd_cycle(input logic [7:0] b [11], input int hold, input int pulses, input logic [127:0] e);
        logic [20:0] f;
        accept_cmd(hold, f);
        check("rd_cmd", 32'(f), 32'({1'b1, 8'h06, 8'h00, 4'd11}));
        repeat (pulses) pulse_drdy();
        exp_q.push_back(e);
        last_exp = e;
        send(b, 11, 1'b0);
        repeat (2) tick();
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end
    initial begin
        logic [7:0] b029 [11];
        logic [7:0] rb [11];
        logic [20:0] f;
        int a0, k0, s0;
        b029 = '{8'h00, 8'h80, 8'h7F, 8'hFF, 8'hF0, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
        repeat (3) tick();
        check("rst_status", status, 32'h0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_temp", temp, 32'h0);
        check("rst_accx", accx, 32'h0);
        check("rst_accy", accy, 32'h0);
        check("rst_accz", accz, 32'h0);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_cfg_ack", 32'(cfg_ack), 32'd0);
        rst = 0;
        en = 1;
        repeat (3) tick();
        pulse_drdy();
        rd_cycle(b029, 0, 0, 128'h00000080_0007FFFF_FFF80000_00000001);
        repeat (3) tick();
        check("sample_count", 32'(n_samp), 32'd1);
        for (int i = 0; i < 11; i++) rb[i] = 8'($urandom_range(0, 255));
        a0 = n_acc;
        pulse_drdy();
        rd_cycle(rb, 20, 0, model(rb));
        check("single_accept", 32'(n_acc - a0), 32'd1);
        for (int i = 0; i < 11; i++) rb[i] = 8'($urandom_range(0, 255));
        drdy = 1;
        tick();
        tick();
        cfg_req = 1;
        cfg_reg = 8'h2D;
        cfg_data = 8'h00;
        rd_cycle(rb, 0, 0, model(rb));
        drdy = 0;
        accept_cmd(0, f);
        check("cfg_cmd", 32'(f), 32'({1'b0, 8'h2D, 8'h00, 4'd1}));
        k0 = n_ack;
        done = 1;
        tick();
        done = 0;
        cfg_req = 0;
        repeat (5) tick();
        check("cfg_ack_count", 32'(n_ack - k0), 32'd1);
        check("idle_after_cfg", 32'(status[0]), 32'd0);
        for (int i = 0; i < 11; i++) rb[i] = 8'($urandom_range(0, 255));
        a0 = n_acc;
        pulse_drdy();
        rd_cycle(rb, 0, 3, model(rb));
        check("overrun_count", 32'(status[15:8]), 32'd2);
        for (int i = 0; i < 11; i++) rb[i] = 8'($urandom_range(0, 255));
        rd_cycle(rb, 0, 0, model(rb));
        repeat (20) tick();
        check("no_extra_read", 32'(cmd_valid), 32'd0);
        check("pending_clear", 32'(status[2]), 32'd0);
        check("followup_reads", 32'(n_acc - a0), 32'd2);
        s0 = n_samp;
        pulse_drdy();
        accept_cmd(0, f);
        send(rb, 5, 1'b1);
        repeat (5) tick();
        check("nack_count", 32'(status[23:16]), 32'd1);
        check("nack_temp_kept", temp, last_exp[127:96]);
        check("nack_accx_kept", accx, last_exp[95:64]);
        check("nack_accy_kept", accy, last_exp[63:32]);
        check("nack_accz_kept", accz, last_exp[31:0]);
        check("nack_no_sample", 32'(n_samp - s0), 32'd0);
        en = 0;
        pulse_drdy();
        repeat (10) tick();
        check("disabled_no_cmd", 32'(cmd_valid), 32'd0);
        check("disabled_no_pending", 32'(status[2]), 32'd0);
        en = 1;
        pulse_drdy();
        accept_cmd(0, f);
        repeat (30) tick();
        check("tmo_not_yet", 32'(status[1]), 32'd0);
        check("tmo_busy", 32'(status[0]), 32'd1);
        repeat (60) tick();
        check("tmo_sticky", 32'(status[1]), 32'd1);
        check("tmo_idle", 32'(status[0]), 32'd0);
        pulse_drdy();
        accept_cmd(0, f);
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1;
            rx_data = 8'hA5;
            tick();
        end
        rx_valid = 0;
        s0 = n_samp;
        rst = 1;
        #1;
        check("mid_rst_status", status, 32'h0);
        check("mid_rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("mid_rst_temp", temp, 32'h0);
        check("mid_rst_accx", accx, 32'h0);
        check("mid_rst_accy", accy, 32'h0);
        check("mid_rst_accz", accz, 32'h0);
        repeat (3) tick();
        rst = 0;
        repeat (10) tick();
        check("post_rst_no_sample", 32'(n_samp - s0), 32'd0);
        check("post_rst_idle", 32'(cmd_valid), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/adxl357_read_scheduler.md
ADXL357_READ_SCHEDULER -- requirements
Module: adxl357_read_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 100000, max cycles from command acceptance to i_done before abort.
REQ-002 SHALL have parameter BURST_LEN, default 11, bytes per sample read (TEMP2 0x06 through ZDATA1 0x10).
REQ-003 SHALL have one clock; reset is asynchronous and active-high: i_clk  in  1  system clock; i_rst  in  1  async active-high reset.
REQ-004 SHALL have i_enable  in  1  scheduler run enable.
REQ-005 SHALL have i_drdy  in  1  asynchronous sensor data-ready.
REQ-006 SHALL have i_cfg_req  in  1  host config-write request, level, held until o_cfg_ack.
REQ-007 SHALL have i_cfg_reg  in  8, i_cfg_data  in  8  config register address and value.
REQ-008 SHALL have o_cfg_ack  out  1  one-cycle pulse when config write completes (any outcome).
REQ-009 SHALL have o_cmd_valid  out  1, i_cmd_ready  in  1, o_cmd_rw  out  1 (1=read), o_cmd_reg  out  8, o_cmd_wdata  out  8, o_cmd_len  out  4  command channel to I2C byte engine.
REQ-010 SHALL have i_rx_valid  in  1, i_rx_data  in  8  read-byte stream; i_done  in  1, i_nack  in  1  transaction-end pulse and NACK flag.
REQ-011 SHALL have o_accx, o_accy, o_accz  out  32  signed samples; o_temp  out  32  unsigned temperature; o_sample_valid  out  1  update pulse.
REQ-012 SHALL have o_status  out  32: [0] busy, [1] timeout sticky, [2] pending read, [15:8] overrun count, [23:16] NACK count, [31:24] zero.

Function
REQ-013 SHALL synchronise i_drdy with two flops and detect rising edges on the synchronised value.
REQ-014 SHALL set a pending-read flag on each drdy edge while i_enable=1; an edge while the flag is already set SHALL increment overrun count (saturating at 255).
REQ-015 SHALL implement states IDLE, RD_CMD, RD_RECV, CFG_CMD, CFG_WAIT, UPDATE.
REQ-016 IDLE: pending read -> RD_CMD (clears pending); else i_cfg_req=1 -> CFG_CMD; pending read wins when both present in same cycle.
REQ-017 RD_CMD: o_cmd_valid=1, rw=1, reg=0x06, len=BURST_LEN; command accepted on cycle with o_cmd_valid & i_cmd_ready -> RD_RECV; command fields SHALL stay stable while valid and unaccepted.
REQ-018 RD_RECV: store each i_rx_valid byte into byte index 0..BURST_LEN-1; bytes beyond BURST_LEN SHALL be ignored.
REQ-019 RD_RECV on i_done: i_nack=0 and exactly BURST_LEN bytes -> UPDATE; otherwise increment NACK count (saturating 255), outputs unchanged, -> IDLE.
REQ-020 UPDATE (one cycle): o_temp = {20'b0, b0[3:0], b1}; X = {b2, b3, b4[7:4]}, Y = {b5, b6, b7[7:4]}, Z = {b8, b9, b10[7:4]}, each 20-bit sign-extended to 32; all four outputs SHALL update in the same cycle with o_sample_valid=1; -> IDLE.
REQ-021 CFG_CMD: o_cmd_valid=1, rw=0, reg=i_cfg_reg, wdata=i_cfg_data (latched on IDLE exit), len=1; accept -> CFG_WAIT.
REQ-022 CFG_WAIT on i_done: pulse o_cfg_ack; NACK increments NACK count; -> IDLE.
REQ-023 A timeout counter SHALL run in RD_RECV and CFG_WAIT; reaching TIMEOUT_CYC sets status[1], aborts to IDLE (CFG_WAIT also pulses o_cfg_ack).
REQ-024 Drdy edges during any busy state SHALL be recorded per REQ-014, never dropped silently.
REQ-025 i_enable=0 SHALL block new read starts and pending-flag setting; an in-flight transaction SHALL complete; config writes remain serviced.
REQ-026 busy = state != IDLE; status[2] = pending flag.

Reset
REQ-027 On i_rst=1, SHALL asynchronously enter IDLE; all outputs, counters, pending flag, sticky timeout, byte buffer and sync flops SHALL be 0.
REQ-028 Reset mid-transaction SHALL drop o_cmd_valid immediately and discard partial bytes; no o_sample_valid or o_cfg_ack pulse.

Verification
REQ-029 drdy edge, engine returns 0x00,0x80,0x7F,0xFF,0xF0,0x80,0x00,0x00,0x00,0x00,0x10 -> o_temp=0x080, o_accx=0x0007FFFF, o_accy=0xFFF80000, o_accz=0x00000001, one o_sample_valid pulse.
REQ-030 i_cmd_ready held low 20 cycles -> o_cmd_valid and fields stable for all 20 cycles, single acceptance.
REQ-031 cfg_req (0x2D, 0x00) and drdy edge same cycle -> read issued first, then write with rw=0, reg=0x2D; o_cfg_ack once.
REQ-032 three drdy edges during one read -> overrun count=2, one follow-up read.
REQ-033 i_done with i_nack=1 after 5 bytes -> NACK count=1, outputs unchanged, no o_sample_valid.
REQ-034 no i_done for TIMEOUT_CYC cycles -> status[1]=1, return to IDLE; i_rst mid-RD_RECV -> all outputs 0.
